bicubic_top: RTL and testbench

- Horizontal 4x bicubic upsampler for a 24-bit RGB pixel stream.
- Accepts one input pixel per handshake and emits one 96-bit beat per input pixel. Each beat holds the four interpolated output pixels at phases 0, 1/4, 2/4 and 3/4 between that pixel and its right neighbour.
- Sits between the access controller's read channel (ac_upsp_*) and its write channel (upsp_ac_*).

---
 rtl/bicubic_pkg.sv | 48 ++++
 rtl/bicubic_phase_mac.sv | 30 +++
 rtl/bicubic_top.sv | 136 +++++++++++++
 tb/tb_bicubic_top.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants for the 4x horizontal bicubic upsampler: tap coefficients, accumulator width, shift/clamp.
// Optional rounding: define BICUBIC_ROUND_EN to add half an LSB before the >>7.
package bicubic_pkg;

    localparam int ACC_W   = 18;
    localparam int CH_W    = 8;
    localparam int COEF_W  = 9;   // 9 bits so the unity tap (+128) is representable
    localparam int NPHASE  = 4;
    localparam int NTAP    = 4;
    localparam int NCHAN   = 3;
    localparam int FRAC_SH = 7;

    typedef enum logic [1:0] {
        PH_0  = 2'd0,
        PH_1Q = 2'd1,
        PH_2Q = 2'd2,
        PH_3Q = 2'd3
    } phase_e;

    // Catmull-Rom style kernel (a = -0.5) at scale 128, taps ordered p[-1], p0, p1, p2.
    localparam logic signed [COEF_W-1:0] COEF [NPHASE][NTAP] = '{
        '{ 9'sd0,   9'sd128, 9'sd0,   9'sd0  },
        '{-9'sd9,   9'sd111, 9'sd29, -9'sd3  },
        '{-9'sd8,   9'sd72,  9'sd72, -9'sd8  },
        '{-9'sd3,   9'sd29,  9'sd111,-9'sd9  }
    };

    function automatic logic [CH_W-1:0] shift_clamp(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
        logic [CH_W-1:0]         res;
`ifdef BICUBIC_ROUND_EN
        biased = acc + $signed(ACC_W'(64));
`else
        biased = acc;
`endif
        shifted = biased >>> FRAC_SH;
        if (shifted < $signed(ACC_W'(0))) begin
            res = '0;
        end else if (shifted > $signed(ACC_W'(255))) begin
            res = '1;
        end else begin
            res = shifted[CH_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bicubic_phase_mac.sv
// One channel, one phase: 4-tap signed multiply-accumulate followed by shift and clamp to 8 bits.
module bicubic_phase_mac
    import bicubic_pkg::*;
(
    input  logic [CH_W-1:0] tap_m1_i,
    input  logic [CH_W-1:0] tap_0_i,
    input  logic [CH_W-1:0] tap_1_i,
    input  logic [CH_W-1:0] tap_2_i,
    input  phase_e          phase_i,
    output logic [CH_W-1:0] pix_o
);

    logic signed [ACC_W-1:0] tap_s  [NTAP];
    logic signed [ACC_W-1:0] coef_s [NTAP];
    logic signed [ACC_W-1:0] acc;

    always_comb begin
        tap_s[0] = $signed(ACC_W'(tap_m1_i));
        tap_s[1] = $signed(ACC_W'(tap_0_i));
        tap_s[2] = $signed(ACC_W'(tap_1_i));
        tap_s[3] = $signed(ACC_W'(tap_2_i));
        acc = '0;
        for (int t = 0; t < NTAP; t++) begin
            coef_s[t] = ACC_W'(COEF[phase_i][t]);
            acc       = acc + coef_s[t] * tap_s[t];
        end
        pix_o = shift_clamp(acc);
    end

endmodule

// File: rtl/bicubic_top.sv
// Horizontal 4x bicubic upsampler: one 24-bit RGB pixel in, one 96-bit beat of four phases out.
// Optional rounding selected by macro BICUBIC_ROUND_EN (see bicubic_pkg).
module bicubic_top
    import bicubic_pkg::*;
#(
    parameter int IMG_WIDTH = 8,
    parameter int PIX_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 upsp_ac_rready,
    input  logic [PIX_W-1:0]     ac_upsp_rdata,
    input  logic                 ac_upsp_rvalid,
    input  logic                 ac_upsp_wready,
    output logic [4*PIX_W-1:0]   upsp_ac_wdata,
    output logic                 upsp_ac_wvalid
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);

    // Column counter, 3-deep pixel history (a oldest, d newest), flush control, output register.
    logic [COL_W-1:0]   col_q, col_d;
    logic [PIX_W-1:0]   win_a_q, win_a_d;
    logic [PIX_W-1:0]   win_b_q, win_b_d;
    logic [PIX_W-1:0]   win_d_q, win_d_d;
    logic               flushing_q, flushing_d;
    logic               flush_cnt_q, flush_cnt_d;
    logic               wvalid_q, wvalid_d;
    logic [4*PIX_W-1:0] wdata_q, wdata_d;

    logic               load_en;
    logic               rready;
    logic               in_fire;
    logic               flush_fire;
    logic               beat_vld;
    logic               left_edge;
    logic [PIX_W-1:0]   tap_m1_pix, tap_0_pix, tap_1_pix, tap_2_pix;
    logic [4*PIX_W-1:0] beat;

    always_comb begin
        load_en    = !wvalid_q || ac_upsp_wready;
        rready     = load_en && !flushing_q;
        in_fire    = ac_upsp_rvalid && rready;
        flush_fire = flushing_q && load_en;
        left_edge  = !flushing_q && (col_q == COL_W'(2));
        beat_vld   = (in_fire && (col_q >= COL_W'(2))) || flush_fire;

        // Beat for column x is formed as pixel x+2 arrives; during flush the newest pixel stands in for p2.
        tap_m1_pix = left_edge  ? win_b_q : win_a_q;
        tap_0_pix  = win_b_q;
        tap_1_pix  = win_d_q;
        tap_2_pix  = flushing_q ? win_d_q : ac_upsp_rdata;
    end

    for (genvar ph = 0; ph < NPHASE; ph++) begin : g_phase
        for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
            bicubic_phase_mac u_mac (
                .tap_m1_i (tap_m1_pix[ch*CH_W +: CH_W]),
                .tap_0_i  (tap_0_pix[ch*CH_W +: CH_W]),
                .tap_1_i  (tap_1_pix[ch*CH_W +: CH_W]),
                .tap_2_i  (tap_2_pix[ch*CH_W +: CH_W]),
                .phase_i  (phase_e'(ph)),
                .pix_o    (beat[ph*PIX_W + ch*CH_W +: CH_W])
            );
        end
    end

    always_comb begin
        col_d       = col_q;
        win_a_d     = win_a_q;
        win_b_d     = win_b_q;
        win_d_d     = win_d_q;
        flushing_d  = flushing_q;
        flush_cnt_d = flush_cnt_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;

        if (in_fire) begin
            win_a_d = win_b_q;
            win_b_d = win_d_q;
            win_d_d = ac_upsp_rdata;
            col_d   = col_q + COL_W'(1);
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                flushing_d  = 1'b1;
                flush_cnt_d = 1'b0;
            end
        end

        // Flush slides the window left while replicating the last pixel on the right.
        if (flush_fire) begin
            win_a_d = win_b_q;
            win_b_d = win_d_q;
            if (flush_cnt_q) begin
                flushing_d  = 1'b0;
                flush_cnt_d = 1'b0;
                col_d       = '0;
            end else begin
                flush_cnt_d = 1'b1;
            end
        end

        if (load_en) begin
            wvalid_d = beat_vld;
            if (beat_vld) begin
                wdata_d = beat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            win_a_q     <= '0;
            win_b_q     <= '0;
            win_d_q     <= '0;
            flushing_q  <= 1'b0;
            flush_cnt_q <= 1'b0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
        end else begin
            col_q       <= col_d;
            win_a_q     <= win_a_d;
            win_b_q     <= win_b_d;
            win_d_q     <= win_d_d;
            flushing_q  <= flushing_d;
            flush_cnt_q <= flush_cnt_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
        end
    end

    assign upsp_ac_rready = rready;
    assign upsp_ac_wvalid = wvalid_q;
    assign upsp_ac_wdata  = wdata_q;

endmodule

// File: tb/tb_bicubic_top.sv
// Bench for bicubic_top: two instances (8- and 4-pixel rows), randomized rows and backpressure, reference model.
module tb_bicubic_top;

    localparam int W0 = 8;
    localparam int W1 = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rvalid, rready, wready, wvalid;
    logic [23:0] rdata [2];
    logic [95:0] wdata [2];

    always #5 clk = ~clk;

    bicubic_top #(.IMG_WIDTH(W0), .PIX_W(24)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .upsp_ac_rready(rready[0]), .ac_upsp_rdata(rdata[0]), .ac_upsp_rvalid(rvalid[0]),
        .ac_upsp_wready(wready[0]), .upsp_ac_wdata(wdata[0]), .upsp_ac_wvalid(wvalid[0])
    );

    bicubic_top #(.IMG_WIDTH(W1), .PIX_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .upsp_ac_rready(rready[1]), .ac_upsp_rdata(rdata[1]), .ac_upsp_rvalid(rvalid[1]),
        .ac_upsp_wready(wready[1]), .upsp_ac_wdata(wdata[1]), .upsp_ac_wvalid(wvalid[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Kernel taps for p[-1], p0, p1, p2 at phases 0, 1/4, 2/4, 3/4.
    int coef [4][4] = '{'{0, 128, 0, 0}, '{-9, 111, 29, -3}, '{-8, 72, 72, -8}, '{-3, 29, 111, -9}};

    logic [23:0] row_buf [16];
    logic [95:0] exp0 [$];
    logic [95:0] exp1 [$];
    logic [95:0] cap [2][16];
    int          cap_idx [2];
    int          seen [2];
    int          stall_cnt [2];
    bit          rand_bp;
    bit          hold_q [2];
    logic [95:0] hold_d [2];

    function automatic logic [95:0] model_beat(input int w, input int x);
        logic [95:0] r;
        int acc, k, v;
        r = '0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int ch = 0; ch < 3; ch++) begin
                acc = 0;
                for (int t = 0; t < 4; t++) begin
                    k = x - 1 + t;
                    if (k < 0) k = 0;
                    if (k > w - 1) k = w - 1;
                    acc += coef[ph][t] * int'(row_buf[k][ch*8 +: 8]);
                end
`ifdef BICUBIC_ROUND_EN
                acc += 64;
`endif
                v = acc >>> 7;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                r[ph*24 + ch*8 +: 8] = 8'(v);
            end
        end
        return r;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic send_pix(input int u, input logic [23:0] px);
        int n = 0;
        bit ok = 1'b0;
        rdata[u]  = px;
        rvalid[u] = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rready[u];
            @(posedge clk);
            #1;
            n++;
        end
        rvalid[u] = 1'b0;
        if (!ok) check_val($sformatf("u%0d accept_timeout", u), 96'd0, 96'd1);
    endtask

    task automatic send_row(input int u, input int w, input int npix, input bit gaps, input int stall_at);
        for (int x = 0; x < w; x++) begin
            if (u == 0) exp0.push_back(model_beat(w, x));
            else        exp1.push_back(model_beat(w, x));
        end
        for (int x = 0; x < npix; x++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (x == stall_at) stall_cnt[u] = 3;
            send_pix(u, row_buf[x]);
        end
    endtask

    task automatic rand_row(input int w);
        for (int x = 0; x < w; x++) row_buf[x] = 24'($urandom);
    endtask

    task automatic drain(input int u);
        int n = 0;
        while (qsize(u) != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check_val($sformatf("u%0d drain_left", u), 96'(qsize(u)), 96'd0);
    endtask

    int base, n;
    logic [95:0] step_exp;

    initial begin
        rst_n     = 1'b0;
        rvalid    = 2'b00;
        wready    = 2'b11;
        rand_bp   = 1'b0;
        for (int u = 0; u < 2; u++) begin
            rdata[u] = '0; stall_cnt[u] = 0; cap_idx[u] = 0; seen[u] = 0;
            hold_q[u] = 1'b0; hold_d[u] = '0;
        end

        fork
            begin : watchdog
                #500000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1);
            end
            begin : wready_drv
                forever begin
                    @(posedge clk);
                    #2;
                    for (int u = 0; u < 2; u++) begin
                        if (stall_cnt[u] > 0) begin
                            wready[u] = 1'b0;
                            stall_cnt[u]--;
                        end else begin
                            wready[u] = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                        end
                    end
                end
            end
            begin : monitor
                logic [95:0] e;
                forever begin
                    @(negedge clk);
                    for (int u = 0; u < 2; u++) begin
                        if (hold_q[u] && rst_n) begin
                            check_val($sformatf("u%0d hold_vld", u), 96'(wvalid[u]), 96'd1);
                            check_val($sformatf("u%0d hold_data", u), wdata[u], hold_d[u]);
                        end
                        hold_q[u] = rst_n && wvalid[u] && !wready[u];
                        if (hold_q[u]) begin
                            hold_d[u] = wdata[u];
                            check_val($sformatf("u%0d rready_hold", u), 96'(rready[u]), 96'd0);
                        end
                        if (rst_n && wvalid[u] && wready[u]) begin
                            if (qsize(u) == 0) begin
                                check_val($sformatf("u%0d extra_beat", u), wdata[u], 96'hx);
                            end else begin
                                e = (u == 0) ? exp0.pop_front() : exp1.pop_front();
                                check_val($sformatf("u%0d beat%0d", u, cap_idx[u]), wdata[u], e);
                                if (cap_idx[u] < 16) cap[u][cap_idx[u]] = wdata[u];
                                cap_idx[u]++;
                                seen[u]++;
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check_val($sformatf("u%0d rst_wvalid", u), 96'(wvalid[u]), 96'd0);
            check_val($sformatf("u%0d rst_wdata", u), wdata[u], 96'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) check_val($sformatf("u%0d rdy_after_rst", u), 96'(rready[u]), 96'd1);

        // Idle with a short wready dip
        stall_cnt[0] = 2;
        stall_cnt[1] = 2;
        repeat (6) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check_val($sformatf("u%0d idle_wvalid", u), 96'(wvalid[u]), 96'd0);
                check_val($sformatf("u%0d idle_rready", u), 96'(rready[u]), 96'd1);
            end
        end
        @(posedge clk);
        #1;

        // Flat row on the 8-wide instance, rready gap at row end
        for (int x = 0; x < W0; x++) row_buf[x] = 24'h808080;
        base = seen[0];
        cap_idx[0] = 0;
        send_row(0, W0, W0, 1'b0, -1);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (rready[0]) break;
            n++;
            @(posedge clk);
            #1;
        end
        check_val("u0 flush_gap", 96'(n), 96'd2);
        drain(0);
        check_val("u0 flat_count", 96'(seen[0] - base), 96'(W0));
        check_val("u0 flat_last", cap[0][W0-1], {4{24'h808080}});

        // Step row on the 4-wide instance
        row_buf[0] = 24'h000000; row_buf[1] = 24'h000000;
        row_buf[2] = 24'hFFFFFF; row_buf[3] = 24'hFFFFFF;
        cap_idx[1] = 0;
        send_row(1, W1, W1, 1'b0, -1);
        drain(1);
`ifdef BICUBIC_ROUND_EN
        step_exp = {24'hCBCBCB, 24'h808080, 24'h343434, 24'h000000};
`else
        step_exp = {24'hCBCBCB, 24'h7F7F7F, 24'h333333, 24'h000000};
`endif
        check_val("u1 step_x0", cap[1][0], 96'd0);
        check_val("u1 step_x1", cap[1][1], step_exp);
        check_val("u1 step_x2", cap[1][2], {96{1'b1}});
        check_val("u1 step_x3", cap[1][3], {96{1'b1}});

        // Undershoot clamps to zero
        row_buf[0] = 24'hFFFFFF; row_buf[1] = 24'h000000;
        row_buf[2] = 24'h000000; row_buf[3] = 24'hFFFFFF;
        cap_idx[1] = 0;
        send_row(1, W1, W1, 1'b0, -1);
        drain(1);
        check_val("u1 under_x1_ph2", 96'(cap[1][1][71:48]), 96'd0);

        // Backpressure: two rows with random wready, gaps and a forced 3-cycle stall
        rand_bp = 1'b1;
        base = seen[0];
        for (int r = 0; r < 2; r++) begin
            rand_row(W0);
            send_row(0, W0, W0, 1'b1, (r == 0) ? 4 : -1);
        end
        drain(0);
        check_val("u0 bp_count", 96'(seen[0] - base), 96'(2 * W0));
        base = seen[1];
        for (int r = 0; r < 3; r++) begin
            rand_row(W1);
            send_row(1, W1, W1, 1'b1, (r == 1) ? 2 : -1);
        end
        drain(1);
        check_val("u1 bp_count", 96'(seen[1] - base), 96'(3 * W1));
        rand_bp = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-row after three pixels, then a clean row
        rand_row(W0);
        send_row(0, W0, 3, 1'b0, -1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("u0 midrst_wvalid", 96'(wvalid[0]), 96'd0);
        check_val("u0 midrst_wdata", wdata[0], 96'd0);
        exp0.delete();
        exp1.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = seen[0];
        rand_bp = 1'b1;
        rand_row(W0);
        send_row(0, W0, W0, 1'b1, -1);
        drain(0);
        check_val("u0 postrst_count", 96'(seen[0] - base), 96'(W0));
        rand_bp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
